oled_pixel_streamer: RTL

- Display-side end of the pixel interface used by the game-screen renderers.
- Scans pixel coordinates, samples the renderer's combinational RGB565 colour word for each coordinate and shifts it serially to the 96x64 SSD1331 OLED.
- Sits between the screen mux (`x`, `y` → `oled_data`) and the OLED pins.
- Controller initialisation and command writes are handled by a separate init block; this block streams pixel data only.

---
 rtl/oled_pixel_streamer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/oled_pixel_streamer.sv
// oled_pixel_streamer
//
// Streams RGB565 pixel data to a 96x64 SSD1331 OLED over a write-only SPI
// link (mode 0, MSB first). The block scans pixel coordinates, presents them
// to the renderer on pixel_x/pixel_y, captures the renderer's combinational
// colour word for one clock (LOAD), then shifts the 16 bits out (SHIFT).
// After the last pixel of a frame, chip select is released for FRAME_GAP
// clocks (GAP) before the next frame starts. Controller initialisation and
// command writes live elsewhere; this block only streams pixel data.
//
// Build option:
//   OLED_TEST_PATTERN_EN - ignore pixel_data and send a coordinate-derived
//                          ramp {x[6:2], y[5:0], x[6:2]} for panel bring-up.
//
// Ports:
//   clk         in   system clock, all state changes on the rising edge
//   rst_n       in   asynchronous active-low reset
//   enable      in   level, 1 = stream frames continuously
//   pixel_x     out  [6:0] column being fetched / sent
//   pixel_y     out  [5:0] row being fetched / sent
//   pixel_data  in   [15:0] RGB565 word from the renderer
//   sclk        out  SPI clock, idles low
//   mosi        out  SPI data, MSB first
//   cs_n        out  chip select, active low
//   dc          out  data/command select, always data
//   frame_begin out  one-clock pulse during the LOAD of pixel (0,0)
//   busy        out  high whenever the streamer is not idle

module oled_pixel_streamer #(
    parameter int WIDTH     = 96,
    parameter int HEIGHT    = 64,
    parameter int CLK_DIV   = 2,
    parameter int FRAME_GAP = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [6:0]  pixel_x,
    output logic [5:0]  pixel_y,
    input  logic [15:0] pixel_data,
    output logic        sclk,
    output logic        mosi,
    output logic        cs_n,
    output logic        dc,
    output logic        frame_begin,
    output logic        busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(FRAME_GAP - 1);
    localparam logic [6:0]       X_LAST   = 7'(WIDTH - 1);
    localparam logic [5:0]       Y_LAST   = 6'(HEIGHT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    logic [1:0]       state;
    logic [15:0]      shreg;
    logic [3:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [15:0]      load_word;
    logic             x_last;
    logic             y_last;

`ifdef OLED_TEST_PATTERN_EN
    logic unused_pixel_data;

    always_comb begin
        load_word         = {pixel_x[6:2], pixel_y, pixel_x[6:2]};
        unused_pixel_data = ^pixel_data;
    end
`else
    always_comb begin
        load_word = pixel_data;
    end
`endif

    always_comb begin
        x_last      = (pixel_x == X_LAST);
        y_last      = (pixel_y == Y_LAST);
        // cs_n stays low across back-to-back pixels of a frame
        cs_n        = !((state == S_LOAD) || (state == S_SHIFT));
        busy        = (state != S_IDLE);
        frame_begin = (state == S_LOAD) && (pixel_x == '0) && (pixel_y == '0);
        dc          = 1'b1;
        // The serial line is the top of the shift register; it only moves
        // when the word is loaded or shifted on an sclk falling edge.
        mosi        = shreg[15];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pixel_x <= '0;
            pixel_y <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            gap_cnt <= '0;
            sclk    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Every restart begins a fresh frame at (0,0)
                    pixel_x <= '0;
                    pixel_y <= '0;
                    if (enable) begin
                        state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    shreg   <= load_word;
                    bit_cnt <= 4'd15;
                    div_cnt <= '0;
                    sclk    <= 1'b0;
                    state   <= S_SHIFT;
                end

                S_SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // Falling edge: present the next bit
                            sclk  <= 1'b0;
                            shreg <= {shreg[14:0], 1'b0};
                            if (bit_cnt == 4'd0) begin
                                if (x_last) begin
                                    pixel_x <= '0;
                                    if (y_last) begin
                                        pixel_y <= '0;
                                        gap_cnt <= '0;
                                        state   <= S_GAP;
                                    end else begin
                                        pixel_y <= pixel_y + 6'd1;
                                        state   <= enable ? S_LOAD : S_IDLE;
                                    end
                                end else begin
                                    pixel_x <= pixel_x + 7'd1;
                                    state   <= enable ? S_LOAD : S_IDLE;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 4'd1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end

                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= enable ? S_LOAD : S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
